// File: rtl/nanorisc_pkg.sv
// Shared constants for the nanorisc register bank: widths, bank encodings,
// special register indices and write-requester IDs.
package nanorisc_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    localparam int MEM_REG_IDX  = 1;
    localparam int ZERO_REG_IDX = 0;

    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_LD   = 2'd1,
        REQ_MV   = 2'd2,
        REQ_NONE = 2'd3
    } req_id_e;

endpackage

// File: rtl/regbank_write_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: the search starts one past the last
// winner and returns a one-hot grant of the first valid requester found.
module rr_pick3 (
    input  logic [2:0] i_valid,
    input  logic [1:0] i_last,
    output logic [2:0] o_gnt
);

    always_comb begin
        o_gnt = 3'b000;
        case (i_last)
            2'd0: begin
                if (i_valid[1])      o_gnt = 3'b010;
                else if (i_valid[2]) o_gnt = 3'b100;
                else if (i_valid[0]) o_gnt = 3'b001;
            end
            2'd1: begin
                if (i_valid[2])      o_gnt = 3'b100;
                else if (i_valid[0]) o_gnt = 3'b001;
                else if (i_valid[1]) o_gnt = 3'b010;
            end
            // last==2 (and the unused encoding 3) restart the search at ALU
            default: begin
                if (i_valid[0])      o_gnt = 3'b001;
                else if (i_valid[1]) o_gnt = 3'b010;
                else if (i_valid[2]) o_gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin write arbiter and one-cycle write sequencer for the register bank,
// with read-after-write hazard detection. Optional: REGARB_ZERO_GUARD_EN drops $zero writes.
module regbank_write_arbiter #(
    parameter int DATA_W = nanorisc_pkg::DATA_W,
    parameter int ADDR_W = nanorisc_pkg::ADDR_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic                alu_bank,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                mv_valid,
    output logic                mv_ready,
    input  logic                mv_bank,
    input  logic [ADDR_W-1:0]   mv_addr,
    input  logic [DATA_W-1:0]   mv_data,
    output logic                RegWrite,
    output logic                isSendType0,
    output logic [ADDR_W-1:0]   writeReg,
    output logic [DATA_W-1:0]   writeData,
    output logic                RegMemWrite,
    output logic [DATA_W-1:0]   memWrite,
    input  logic [2:0]          rd_bank,
    input  logic [3*ADDR_W-1:0] rd_addr,
    output logic                hazard,
    output logic [1:0]          grant_id
);

    import nanorisc_pkg::*;

    logic [2:0]        w_valid;
    logic [2:0]        w_gnt;
    req_id_e           w_win_id;
    logic              w_sel_bank;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_zero_drop;
    logic              w_match;

    logic [1:0]        r_last;
    logic              r_reg_write;
    logic              r_mem_write;
    logic              r_send;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mdata;
    logic [1:0]        r_grant_id;
    logic              r_tgt_bank;
    logic [ADDR_W-1:0] r_tgt_addr;

    assign w_valid = {mv_valid, ld_valid, alu_valid};

    rr_pick3 u_pick (
        .i_valid (w_valid),
        .i_last  (r_last),
        .o_gnt   (w_gnt)
    );

    assign alu_ready = w_gnt[0] & ~reset;
    assign ld_ready  = w_gnt[1] & ~reset;
    assign mv_ready  = w_gnt[2] & ~reset;

    always_comb begin
        w_win_id = REQ_NONE;
        if (w_gnt[0])      w_win_id = REQ_ALU;
        else if (w_gnt[1]) w_win_id = REQ_LD;
        else if (w_gnt[2]) w_win_id = REQ_MV;
    end

    assign w_sel_bank = w_gnt[2] ? mv_bank : alu_bank;
    assign w_sel_addr = w_gnt[2] ? mv_addr : alu_addr;
    assign w_sel_data = w_gnt[2] ? mv_data : alu_data;

`ifdef REGARB_ZERO_GUARD_EN
    assign w_zero_drop = (w_gnt[0] | w_gnt[2]) && (w_sel_bank == BANK_A) &&
                         (w_sel_addr == ADDR_W'(ZERO_REG_IDX));
`else
    assign w_zero_drop = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last      <= 2'd2;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
            r_send      <= 1'b0;
            r_wreg      <= '0;
            r_wdata     <= '0;
            r_mdata     <= '0;
            r_grant_id  <= REQ_NONE;
            r_tgt_bank  <= BANK_A;
            r_tgt_addr  <= '0;
        end else begin
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
            r_grant_id  <= REQ_NONE;
            if (|w_gnt) begin
                // A dropped $zero write still counts as a turn for fairness
                r_last <= w_win_id;
                if (w_gnt[1]) begin
                    r_mem_write <= 1'b1;
                    r_mdata     <= ld_data;
                    r_tgt_bank  <= BANK_A;
                    r_tgt_addr  <= ADDR_W'(MEM_REG_IDX);
                    r_grant_id  <= REQ_LD;
                end else if (!w_zero_drop) begin
                    r_reg_write <= 1'b1;
                    r_send      <= w_sel_bank;
                    r_wreg      <= w_sel_addr;
                    r_wdata     <= w_sel_data;
                    r_tgt_bank  <= w_sel_bank;
                    r_tgt_addr  <= w_sel_addr;
                    r_grant_id  <= w_win_id;
                end
            end
        end
    end

    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((rd_bank[i] == r_tgt_bank) && (rd_addr[i*ADDR_W +: ADDR_W] == r_tgt_addr)) begin
                w_match = 1'b1;
            end
        end
    end

    assign hazard      = (r_reg_write | r_mem_write) & w_match;
    assign RegWrite    = r_reg_write;
    assign isSendType0 = r_send;
    assign writeReg    = r_wreg;
    assign writeData   = r_wdata;
    assign RegMemWrite = r_mem_write;
    assign memWrite    = r_mdata;
    assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed, table-driven bench for regbank_write_arbiter, plus hand sequences for
// hazard re-evaluation and asynchronous reset mid-issue.
module tb_regbank_write_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       alu_valid, alu_ready, alu_bank;
    logic [1:0] alu_addr;
    logic [7:0] alu_data;
    logic       ld_valid, ld_ready;
    logic [7:0] ld_data;
    logic       mv_valid, mv_ready, mv_bank;
    logic [1:0] mv_addr;
    logic [7:0] mv_data;
    logic       RegWrite, isSendType0, RegMemWrite, hazard;
    logic [1:0] writeReg, grant_id;
    logic [7:0] writeData, memWrite;
    logic [2:0] rd_bank;
    logic [5:0] rd_addr;

    int n_tests = 0;
    int n_fail  = 0;

    regbank_write_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_bank    (alu_bank),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .mv_valid    (mv_valid),
        .mv_ready    (mv_ready),
        .mv_bank     (mv_bank),
        .mv_addr     (mv_addr),
        .mv_data     (mv_data),
        .RegWrite    (RegWrite),
        .isSendType0 (isSendType0),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .RegMemWrite (RegMemWrite),
        .memWrite    (memWrite),
        .rd_bank     (rd_bank),
        .rd_addr     (rd_addr),
        .hazard      (hazard),
        .grant_id    (grant_id)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       alu_v;
        logic       alu_b;
        logic [1:0] alu_a;
        logic [7:0] alu_d;
        logic       ld_v;
        logic [7:0] ld_d;
        logic       mv_v;
        logic       mv_b;
        logic [1:0] mv_a;
        logic [7:0] mv_d;
        logic [2:0] rd_b;
        logic [5:0] rd_a;
        logic [2:0] e_rdy;   // {mv, ld, alu}
        logic       e_rw;
        logic       e_rmw;
        logic       e_send;
        logic [1:0] e_wreg;
        logic [7:0] e_wdata;
        logic [7:0] e_mdata;
        logic [1:0] e_gid;
        logic       e_haz;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_valid = v.alu_v; alu_bank = v.alu_b; alu_addr = v.alu_a; alu_data = v.alu_d;
        ld_valid  = v.ld_v;  ld_data  = v.ld_d;
        mv_valid  = v.mv_v;  mv_bank  = v.mv_b;  mv_addr  = v.mv_a;  mv_data  = v.mv_d;
        rd_bank   = v.rd_b;  rd_addr  = v.rd_a;
    endtask

    task automatic chk_outputs(input string tag, input vec_t v);
        chk({tag, ".RegWrite"},    int'(RegWrite),    int'(v.e_rw));
        chk({tag, ".RegMemWrite"}, int'(RegMemWrite), int'(v.e_rmw));
        chk({tag, ".isSendType0"}, int'(isSendType0), int'(v.e_send));
        chk({tag, ".writeReg"},    int'(writeReg),    int'(v.e_wreg));
        chk({tag, ".writeData"},   int'(writeData),   int'(v.e_wdata));
        chk({tag, ".memWrite"},    int'(memWrite),    int'(v.e_mdata));
        chk({tag, ".grant_id"},    int'(grant_id),    int'(v.e_gid));
        chk({tag, ".hazard"},      int'(hazard),      int'(v.e_haz));
    endtask

    initial begin
        //            alu v b a  d       ld v d      mv v b a  d       rd_b    rd_a
        //            rdy     rw rmw snd wreg wdata  mdata gid haz
        vecs[0]  = '{1,0,2,8'h5A, 0,8'h00, 0,0,0,8'h00, 3'b000,6'b000000,
                     3'b001, 1,0,0,2,8'h5A,8'h00,0,0};
        vecs[1]  = '{0,0,0,8'h00, 0,8'h00, 1,1,1,8'h99, 3'b000,6'b000000,
                     3'b100, 1,0,1,1,8'h99,8'h00,2,0};
        vecs[2]  = '{0,0,0,8'h00, 0,8'h00, 0,0,0,8'h00, 3'b000,6'b000000,
                     3'b000, 0,0,1,1,8'h99,8'h00,3,0};
        vecs[3]  = '{1,1,3,8'h11, 1,8'h22, 1,0,2,8'h44, 3'b000,6'b000000,
                     3'b001, 1,0,1,3,8'h11,8'h00,0,0};
        vecs[4]  = '{1,1,3,8'h11, 1,8'h22, 1,0,2,8'h44, 3'b000,6'b000000,
                     3'b010, 0,1,1,3,8'h11,8'h22,1,0};
        vecs[5]  = '{1,1,3,8'h11, 1,8'h22, 1,0,2,8'h44, 3'b000,6'b000000,
                     3'b100, 1,0,0,2,8'h44,8'h22,2,0};
        vecs[6]  = '{1,1,3,8'h11, 1,8'h22, 1,0,2,8'h44, 3'b000,6'b000000,
                     3'b001, 1,0,1,3,8'h11,8'h22,0,0};
        vecs[7]  = '{1,1,3,8'h11, 1,8'h22, 1,0,2,8'h44, 3'b000,6'b000000,
                     3'b010, 0,1,1,3,8'h11,8'h22,1,0};
        // read port 2 at A[2] collides with the MV write to A[2]
        vecs[8]  = '{1,1,3,8'h11, 1,8'h22, 1,0,2,8'h44, 3'b000,6'b100000,
                     3'b100, 1,0,0,2,8'h44,8'h22,2,1};
        // read port 1 at A[1] collides with the load into $mem
        vecs[9]  = '{0,0,0,8'h00, 1,8'h33, 0,0,0,8'h00, 3'b000,6'b000100,
                     3'b010, 0,1,0,2,8'h44,8'h33,1,1};
`ifdef REGARB_ZERO_GUARD_EN
        vecs[10] = '{1,0,0,8'hFF, 0,8'h00, 0,0,0,8'h00, 3'b000,6'b000000,
                     3'b001, 0,0,0,2,8'h44,8'h33,3,0};
        vecs[11] = '{0,0,0,8'h00, 1,8'h77, 1,1,3,8'hA7, 3'b000,6'b000000,
                     3'b010, 0,1,0,2,8'h44,8'h77,1,0};
`else
        vecs[10] = '{1,0,0,8'hFF, 0,8'h00, 0,0,0,8'h00, 3'b000,6'b000000,
                     3'b001, 1,0,0,0,8'hFF,8'h33,0,1};
        vecs[11] = '{0,0,0,8'h00, 1,8'h77, 1,1,3,8'hA7, 3'b000,6'b000000,
                     3'b010, 0,1,0,0,8'hFF,8'h77,1,0};
`endif
        vecs[12] = '{0,0,0,8'h00, 0,8'h00, 1,1,3,8'hA7, 3'b000,6'b000000,
                     3'b100, 1,0,1,3,8'hA7,8'h77,2,0};

        // Reset with ALU requesting: no ready may leak out while reset is high
        reset = 1'b1;
        drive(vecs[0]);
        #7;
        chk("rst.alu_ready", int'(alu_ready), 0);
        chk("rst.RegWrite", int'(RegWrite), 0);
        chk("rst.RegMemWrite", int'(RegMemWrite), 0);
        chk("rst.isSendType0", int'(isSendType0), 0);
        chk("rst.writeReg", int'(writeReg), 0);
        chk("rst.writeData", int'(writeData), 0);
        chk("rst.memWrite", int'(memWrite), 0);
        chk("rst.hazard", int'(hazard), 0);
        chk("rst.grant_id", int'(grant_id), 3);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            if (i != 0) @(negedge clock);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.ready", i), int'({mv_ready, ld_ready, alu_ready}),
                int'(vecs[i].e_rdy));
            @(posedge clock);
            #1;
            chk_outputs($sformatf("v%0d", i), vecs[i]);
            if (i == 9) begin
                // Same in-flight load, read moved off the target
                rd_addr = 6'b001000;
                #1;
                chk("ld_haz.addr2", int'(hazard), 0);
                rd_bank = 3'b010;
                rd_addr = 6'b000100;
                #1;
                chk("ld_haz.bankB", int'(hazard), 0);
            end
        end

        // MV write to B[3] is in flight; reset mid-cycle clears it at once
        #2;
        reset = 1'b1;
        #1;
        chk("midrst.RegWrite", int'(RegWrite), 0);
        chk("midrst.grant_id", int'(grant_id), 3);
        chk("midrst.isSendType0", int'(isSendType0), 0);
        chk("midrst.writeReg", int'(writeReg), 0);
        chk("midrst.mv_ready", int'(mv_ready), 0);

        // After reset the pointer is back at 2, so ALU beats LD
        @(negedge clock);
        reset = 1'b0;
        drive(vecs[3]);
        mv_valid = 1'b0;
        #1;
        chk("postrst.ready", int'({mv_ready, ld_ready, alu_ready}), 1);
        @(posedge clock);
        #1;
        chk("postrst.grant_id", int'(grant_id), 0);
        chk("postrst.writeData", int'(writeData), 8'h11);
        @(negedge clock);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        @(posedge clock);
        #1;
        chk("postrst.idle_grant", int'(grant_id), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
